// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared types and constants for the FIR sequencer slice.
//  Revision    : 1.0  initial release
// ============================================================================
package fir_pkg;

    // Default coefficient/sample memory depth.
    localparam int MAX_TAPS_DFLT = 64;

    // Bit position of the coefficient index inside the core address bus.
    localparam int TAP_LSB = 8;

    // Sample memory {CEN,WEN} encodings, active-low.
    localparam logic [1:0] DLOAD_IDLE = 2'b11;
    localparam logic [1:0] DLOAD_RD   = 2'b01;
    localparam logic [1:0] DLOAD_WR   = 2'b00;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_COEF   = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_MAC    = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_RESULT = 3'd6
    } state_t;

    // A tap count is usable when it is non-zero and fits the memories.
    function automatic logic ntaps_legal(input logic [6:0] n, input int max_taps);
        return (n != 7'd0) && (int'(n) <= max_taps);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_ring_ptr.sv
`default_nettype none
// ============================================================================
//  Module      : fir_ring_ptr
//  Description : Modular pointer over 0..i_max with load, increment and
//                decrement. Increment wraps i_max->0, decrement wraps 0->i_max.
//                Priority: load, then inc, then dec.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_ring_ptr #(
    parameter int PW = 6
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_load,
    input  logic [PW-1:0] i_load_val,
    input  logic          i_inc,
    input  logic          i_dec,
    input  logic [PW-1:0] i_max,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] r_ptr;

    // Pointer register with run-time wrap bound.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_load) begin
            r_ptr <= i_load_val;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == i_max) ? '0 : r_ptr + 1'b1;
        end else if (i_dec) begin
            r_ptr <= (r_ptr == '0) ? i_max : r_ptr - 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fir_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fir_seq_ctrl
//  Description : Sequencer for a time-multiplexed FIR core. Loads the
//                coefficients, zero-fills sample history, then for every
//                input sample writes it to the circular sample memory and
//                runs NTAPS read/multiply/accumulate cycles before offering
//                the result on a valid/ready port.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_seq_ctrl
    import fir_pkg::*;
#(
    parameter int MAX_TAPS = MAX_TAPS_DFLT,
    parameter int AW       = 14,
    parameter int MUL_LAT  = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cfg_start,
    input  logic [6:0]    i_cfg_ntaps,
    input  logic          i_cfg_abort,
    input  logic          i_coef_valid,
    output logic          o_coef_ready,
    input  logic          i_smp_valid,
    output logic          o_smp_ready,
    output logic          o_res_valid,
    input  logic          i_res_ready,
    output logic [AW-1:0] o_addr,
    output logic [1:0]    o_dload,
    output logic          o_cload,
    output logic          o_zero_din,
    output logic          o_mul_en,
    output logic          o_acc_en,
    output logic          o_acc_clr,
    output logic          o_busy,
    output logic          o_err
);

    localparam int PW = $clog2(MAX_TAPS);

    // State and counters. r_cnt serves as cidx, zidx, tap and drain count.
    state_t        r_state, w_state_nxt;
    logic [PW-1:0] r_nm1,   w_nm1_nxt;
    logic [PW-1:0] r_cnt,   w_cnt_nxt;

    // Registered core-facing and handshake outputs.
    logic [1:0]    r_dload,     w_dload_nxt;
    logic [AW-1:0] r_addr,      w_addr_nxt;
    logic          r_zero_din,  w_zero_nxt;
    logic          r_mul_en,    w_mul_nxt;
    logic          r_mul_first, w_first_nxt;
    logic          r_coef_rdy,  w_coef_rdy_nxt;
    logic          r_smp_rdy,   w_smp_rdy_nxt;
    logic          r_res_vld,   w_res_vld_nxt;
    logic          r_busy;
    logic          r_err,       w_err_nxt;

    // acc_en/acc_clr trail mul_en by the multiplier latency.
    logic [MUL_LAT-1:0] r_acc_dly;
    logic [MUL_LAT-1:0] r_clr_dly;

    // Pointer controls.
    logic          w_wp_load, w_wp_inc, w_rp_load, w_rp_dec;
    logic [PW-1:0] w_wptr, w_rptr;

    fir_ring_ptr #(.PW(PW)) u_wptr (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_wp_load),
        .i_load_val ('0),
        .i_inc      (w_wp_inc),
        .i_dec      (1'b0),
        .i_max      (r_nm1),
        .o_ptr      (w_wptr)
    );

    fir_ring_ptr #(.PW(PW)) u_rptr (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_rp_load),
        .i_load_val (w_wptr),
        .i_inc      (1'b0),
        .i_dec      (w_rp_dec),
        .i_max      (r_nm1),
        .o_ptr      (w_rptr)
    );

    // Next-state and next-output decode. Core commands issued on an edge
    // appear on the outputs for the following cycle, so the sample write
    // shows during the first MAC cycle and each read one cycle after its
    // tap is sequenced; DRAIN holds MUL_LAT+1 cycles so the last acc_en
    // lands just before res_valid.
    always_comb begin
        w_state_nxt    = r_state;
        w_nm1_nxt      = r_nm1;
        w_cnt_nxt      = r_cnt;
        w_dload_nxt    = DLOAD_IDLE;
        w_addr_nxt     = '0;
        w_zero_nxt     = 1'b0;
        w_mul_nxt      = 1'b0;
        w_first_nxt    = 1'b0;
        w_coef_rdy_nxt = 1'b0;
        w_smp_rdy_nxt  = 1'b0;
        w_res_vld_nxt  = 1'b0;
        w_err_nxt      = 1'b0;
        w_wp_load      = 1'b0;
        w_wp_inc       = 1'b0;
        w_rp_load      = 1'b0;
        w_rp_dec       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_cfg_start) begin
                    if (ntaps_legal(i_cfg_ntaps, MAX_TAPS)) begin
                        w_nm1_nxt      = PW'(i_cfg_ntaps - 7'd1);
                        w_cnt_nxt      = '0;
                        w_state_nxt    = ST_COEF;
                        w_coef_rdy_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_COEF: begin
                if (i_coef_valid) begin
                    if (r_cnt == r_nm1) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_CLEAR;
                        w_dload_nxt = DLOAD_WR;
                        w_zero_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt              = r_cnt + 1'b1;
                        w_coef_rdy_nxt         = 1'b1;
                        w_addr_nxt[PW-1:0]     = r_cnt + 1'b1;
                    end
                end else begin
                    w_coef_rdy_nxt     = 1'b1;
                    w_addr_nxt[PW-1:0] = r_cnt;
                end
            end
            ST_CLEAR: begin
                if (r_cnt == r_nm1) begin
                    w_state_nxt   = ST_WAIT;
                    w_wp_load     = 1'b1;
                    w_smp_rdy_nxt = 1'b1;
                end else begin
                    w_cnt_nxt          = r_cnt + 1'b1;
                    w_dload_nxt        = DLOAD_WR;
                    w_zero_nxt         = 1'b1;
                    w_addr_nxt[PW-1:0] = r_cnt + 1'b1;
                end
            end
            ST_WAIT: begin
                if (i_smp_valid) begin
                    w_state_nxt        = ST_MAC;
                    w_rp_load          = 1'b1;
                    w_cnt_nxt          = '0;
                    w_dload_nxt        = DLOAD_WR;
                    w_addr_nxt[PW-1:0] = w_wptr;
                end else begin
                    w_smp_rdy_nxt = 1'b1;
                end
            end
            ST_MAC: begin
                w_dload_nxt                = DLOAD_RD;
                w_addr_nxt[PW-1:0]         = w_rptr;
                w_addr_nxt[TAP_LSB +: PW]  = r_cnt;
                w_mul_nxt                  = 1'b1;
                w_first_nxt                = (r_cnt == '0);
                w_rp_dec                   = 1'b1;
                if (r_cnt == r_nm1) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == PW'(MUL_LAT)) begin
                    w_state_nxt   = ST_RESULT;
                    w_res_vld_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_RESULT: begin
                if (i_res_ready) begin
                    w_state_nxt   = ST_WAIT;
                    w_wp_inc      = 1'b1;
                    w_smp_rdy_nxt = 1'b1;
                end else begin
                    w_res_vld_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Abort wins over every transition and silences the core.
        if (i_cfg_abort) begin
            w_state_nxt    = ST_IDLE;
            w_dload_nxt    = DLOAD_IDLE;
            w_addr_nxt     = '0;
            w_zero_nxt     = 1'b0;
            w_mul_nxt      = 1'b0;
            w_first_nxt    = 1'b0;
            w_coef_rdy_nxt = 1'b0;
            w_smp_rdy_nxt  = 1'b0;
            w_res_vld_nxt  = 1'b0;
            w_err_nxt      = 1'b0;
            w_wp_load      = 1'b0;
            w_wp_inc       = 1'b0;
            w_rp_load      = 1'b0;
            w_rp_dec       = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_nm1       <= '0;
            r_cnt       <= '0;
            r_dload     <= DLOAD_IDLE;
            r_addr      <= '0;
            r_zero_din  <= 1'b0;
            r_mul_en    <= 1'b0;
            r_mul_first <= 1'b0;
            r_coef_rdy  <= 1'b0;
            r_smp_rdy   <= 1'b0;
            r_res_vld   <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_nm1       <= w_nm1_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dload     <= w_dload_nxt;
            r_addr      <= w_addr_nxt;
            r_zero_din  <= w_zero_nxt;
            r_mul_en    <= w_mul_nxt;
            r_mul_first <= w_first_nxt;
            r_coef_rdy  <= w_coef_rdy_nxt;
            r_smp_rdy   <= w_smp_rdy_nxt;
            r_res_vld   <= w_res_vld_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_err       <= w_err_nxt;
        end
    end

    // Multiplier-latency delay line for acc_en and acc_clr; flushed on abort.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_acc_dly <= '0;
            r_clr_dly <= '0;
        end else if (i_cfg_abort) begin
            r_acc_dly <= '0;
            r_clr_dly <= '0;
        end else begin
            r_acc_dly[0] <= r_mul_en;
            r_clr_dly[0] <= r_mul_en & r_mul_first;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_acc_dly[i] <= r_acc_dly[i-1];
                r_clr_dly[i] <= r_clr_dly[i-1];
            end
        end
    end

    assign o_cload      = i_coef_valid && (r_state == ST_COEF);
    assign o_coef_ready = r_coef_rdy;
    assign o_smp_ready  = r_smp_rdy;
    assign o_res_valid  = r_res_vld;
    assign o_addr       = r_addr;
    assign o_dload      = r_dload;
    assign o_zero_din   = r_zero_din;
    assign o_mul_en     = r_mul_en;
    assign o_acc_en     = r_acc_dly[MUL_LAT-1];
    assign o_acc_clr    = r_clr_dly[MUL_LAT-1];
    assign o_busy       = r_busy;
    assign o_err        = r_err;

endmodule
`default_nettype wire
